// File: rtl/ad7984_acq_sequencer_if.sv
// Wishbone slave bus bundle for the AD7984 acquisition sequencer.
interface ad7984_acq_sequencer_if #(
    parameter int unsigned ADR_W = 8,
    parameter int unsigned DAT_W = 32
);
    logic             WBS_CYC;
    logic             WBS_STB;
    logic             WBS_WE;
    logic             WBS_RD;
    logic [3:0]       WBS_BYTE_STB;
    logic [ADR_W-1:0] WBS_ADR;
    logic [DAT_W-1:0] WBS_WR_DAT;
    logic [DAT_W-1:0] WBS_RD_DAT;
    logic             WBS_ACK;

    modport master (
        output WBS_CYC, WBS_STB, WBS_WE, WBS_RD, WBS_BYTE_STB, WBS_ADR, WBS_WR_DAT,
        input  WBS_RD_DAT, WBS_ACK
    );

    modport slave (
        input  WBS_CYC, WBS_STB, WBS_WE, WBS_RD, WBS_BYTE_STB, WBS_ADR, WBS_WR_DAT,
        output WBS_RD_DAT, WBS_ACK
    );
endinterface

// File: rtl/ad7984_acq_sequencer.sv
// AD7984 acquisition sequencer: periodic CNV/SCK sequencing, sample FIFO,
// fill-level SDMA request and interrupt, all behind one Wishbone slave slot.
module ad7984_acq_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 17,
    parameter int unsigned MUX_ADDR_WIDHT = 9,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SAMPLE_BITS    = 16,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                         WB_CLK,
    input  logic                         WB_RST_N,
    ad7984_acq_sequencer_if.slave        wb,
    output logic                         CNV,
    output logic                         SCK,
    input  logic                         SDO,
    output logic                         SDMA_REQ,
    output logic                         IRQ
);
    localparam int unsigned AW = ADDR_WIDTH - MUX_ADDR_WIDHT;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SB = SAMPLE_BITS;
    localparam int unsigned BW = $clog2(SB + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_PUSH = 2'd3;

    logic          ack_q, en_q, oneshot_q, ie_q, ovf_q, miss_q, sdma_q, irq_q;
    logic [15:0]   period_q, tmr_q;
    logic [7:0]    tconv_q, thresh_q;
    logic [3:0]    sck_div_q;
    logic [DW-1:0] rd_dat_q, rd_mux_c;

    logic [1:0]    state_q, state_nx;
    logic [7:0]    cnt_q, cnt_nx;
    logic [BW-1:0] bit_q, bit_nx;
    logic [SB-1:0] sh_q, sh_nx;
    logic          cnv_q, cnv_nx, sck_q, sck_nx, push_c;

    logic [SB-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [LW-1:0] level_q;

    logic       req_c, wr_c, rd_c, ctrl_wr_c, abort_c, fifo_clr_c, tick_c;
    logic       pop_c, empty_c, full_c, do_push_c, ovf_set_c, miss_set_c, sdma_c;
    logic [2:0] sel_c;
    logic       unused_bits;

    assign req_c      = wb.WBS_CYC & wb.WBS_STB & ~ack_q;
    assign wr_c       = req_c & wb.WBS_WE & (|wb.WBS_BYTE_STB);
    assign rd_c       = req_c & ~wb.WBS_WE & wb.WBS_RD;
    assign sel_c      = wb.WBS_ADR[4:2];
    assign ctrl_wr_c  = wr_c & (sel_c == 3'd0);
    assign abort_c    = ctrl_wr_c & en_q & ~wb.WBS_WR_DAT[0];
    assign fifo_clr_c = ctrl_wr_c & wb.WBS_WR_DAT[2];
    assign unused_bits = ^{wb.WBS_ADR[AW-1:5], wb.WBS_ADR[1:0], wb.WBS_WR_DAT[DW-1:18]};

    assign tick_c     = (en_q & (tmr_q == 16'd0)) | oneshot_q;
    assign miss_set_c = tick_c & (state_q != S_IDLE);
    assign empty_c    = (level_q == '0);
    assign full_c     = (level_q == LW'(FIFO_DEPTH));
    assign pop_c      = rd_c & (sel_c == 3'd5) & ~empty_c;
    assign do_push_c  = push_c & (~full_c | pop_c);
    assign ovf_set_c  = push_c & full_c & ~pop_c;
    assign sdma_c     = (thresh_q != 8'd0) & (16'(level_q) >= 16'(thresh_q));

    // Register read mux; DATA returns the FIFO head with a valid flag in the MSB.
    always_comb begin
        rd_mux_c = '0;
        case (sel_c)
            3'd0: rd_mux_c = DW'({ie_q, 2'b00, en_q});
            3'd1: rd_mux_c = DW'(period_q);
            3'd2: rd_mux_c = DW'(tconv_q);
            3'd3: rd_mux_c = DW'(sck_div_q);
            3'd4: begin
                rd_mux_c[7:0] = 8'(level_q);
                rd_mux_c[8]   = empty_c;
                rd_mux_c[9]   = full_c;
                rd_mux_c[16]  = ovf_q;
                rd_mux_c[17]  = miss_q;
            end
            3'd5: if (!empty_c) begin
                rd_mux_c[DW-1]   = 1'b1;
                rd_mux_c[SB-1:0] = mem[rp_q];
            end
            3'd6: rd_mux_c = DW'(thresh_q);
            default: rd_mux_c = '0;
        endcase
    end

    // Bus registers, sticky flags, period timer and registered status outputs.
    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_N) begin
            ack_q <= 1'b0; en_q <= 1'b0; oneshot_q <= 1'b0; ie_q <= 1'b0;
            ovf_q <= 1'b0; miss_q <= 1'b0; sdma_q <= 1'b0; irq_q <= 1'b0;
            period_q <= '0; tmr_q <= '0; tconv_q <= '0; thresh_q <= '0;
            sck_div_q <= '0; rd_dat_q <= '0;
        end else begin
            ack_q     <= req_c;
            oneshot_q <= 1'b0;
            if (ctrl_wr_c) begin
                en_q      <= wb.WBS_WR_DAT[0];
                oneshot_q <= wb.WBS_WR_DAT[1];
                ie_q      <= wb.WBS_WR_DAT[3];
            end
            if (wr_c && sel_c == 3'd1) period_q  <= wb.WBS_WR_DAT[15:0];
            if (wr_c && sel_c == 3'd2) tconv_q   <= wb.WBS_WR_DAT[7:0];
            if (wr_c && sel_c == 3'd3) sck_div_q <= wb.WBS_WR_DAT[3:0];
            if (wr_c && sel_c == 3'd6) thresh_q  <= wb.WBS_WR_DAT[7:0];
            if (ovf_set_c) ovf_q <= 1'b1;
            else if (wr_c && sel_c == 3'd4 && wb.WBS_WR_DAT[16]) ovf_q <= 1'b0;
            if (miss_set_c) miss_q <= 1'b1;
            else if (wr_c && sel_c == 3'd4 && wb.WBS_WR_DAT[17]) miss_q <= 1'b0;
            rd_dat_q <= rd_c ? rd_mux_c : '0;
            sdma_q   <= sdma_c;
            irq_q    <= ie_q & (sdma_c | ovf_q | miss_q);
            if (!en_q)                 tmr_q <= '0;
            else if (tmr_q == 16'd0)   tmr_q <= period_q - 16'd1;
            else                       tmr_q <= tmr_q - 16'd1;
        end
    end

    // Conversion sequencer next-state logic; an EN clear aborts from any state.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        bit_nx   = bit_q;
        sh_nx    = sh_q;
        cnv_nx   = 1'b0;
        sck_nx   = 1'b0;
        push_c   = 1'b0;
        case (state_q)
            S_IDLE: if (tick_c) begin
                state_nx = S_CONV;
                cnv_nx   = 1'b1;
                cnt_nx   = tconv_q;
            end
            S_CONV: if (cnt_q == 8'd0) begin
                state_nx = S_READ;
                cnt_nx   = 8'(sck_div_q);
                bit_nx   = BW'(SB - 1);
            end else begin
                cnt_nx = cnt_q - 8'd1;
                cnv_nx = 1'b1;
            end
            S_READ: begin
                sck_nx = sck_q;
                if (cnt_q != 8'd0) begin
                    cnt_nx = cnt_q - 8'd1;
                end else begin
                    cnt_nx = 8'(sck_div_q);
                    if (!sck_q) begin
                        sck_nx = 1'b1;
                        sh_nx  = SB'({sh_q, SDO});
                    end else begin
                        sck_nx = 1'b0;
                        if (bit_q == '0) state_nx = S_PUSH;
                        else             bit_nx   = bit_q - 1'b1;
                    end
                end
            end
            S_PUSH: begin
                push_c   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort_c) begin
            state_nx = S_IDLE;
            cnv_nx   = 1'b0;
            sck_nx   = 1'b0;
            push_c   = 1'b0;
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_N) begin
            state_q <= S_IDLE; cnt_q <= '0; bit_q <= '0; sh_q <= '0;
            cnv_q <= 1'b0; sck_q <= 1'b0;
        end else begin
            state_q <= state_nx; cnt_q <= cnt_nx; bit_q <= bit_nx; sh_q <= sh_nx;
            cnv_q <= cnv_nx; sck_q <= sck_nx;
        end
    end

    // Sample FIFO pointers; a clear empties it without touching OVF.
    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_N || fifo_clr_c) begin
            wp_q <= '0; rp_q <= '0; level_q <= '0;
        end else begin
            if (do_push_c) wp_q <= wp_q + 1'b1;
            if (pop_c)     rp_q <= rp_q + 1'b1;
            level_q <= level_q + LW'(do_push_c) - LW'(pop_c);
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (do_push_c) mem[wp_q] <= sh_q;
    end

    assign wb.WBS_ACK    = ack_q;
    assign wb.WBS_RD_DAT = rd_dat_q;
    assign CNV           = cnv_q;
    assign SCK           = sck_q;
    assign SDMA_REQ      = sdma_q;
    assign IRQ           = irq_q;
endmodule

// File: tb/tb_ad7984_acq_sequencer.sv
// Directed bench for ad7984_acq_sequencer with a behavioural AD7984 SDO source.
module tb_ad7984_acq_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cnv, sck, sdo, sdma, irq;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned cyc_n    = 0;
    int unsigned n_cnv    = 0;
    int unsigned ovf_base = 0;
    int unsigned sck_cnt  = 0;
    int unsigned sck_base = 0;
    int unsigned rise_q [$];
    logic        auto_inc = 1'b0;
    logic [15:0] sdo_word = 16'h0000;
    logic [15:0] cur      = 16'h0000;

    always #5 clk = ~clk;

    ad7984_acq_sequencer_if #(.ADR_W(8), .DAT_W(32)) wb ();

    ad7984_acq_sequencer dut (
        .WB_CLK   (clk),
        .WB_RST_N (rst_n),
        .wb       (wb),
        .CNV      (cnv),
        .SCK      (sck),
        .SDO      (sdo),
        .SDMA_REQ (sdma),
        .IRQ      (irq)
    );

    // ADC model: MSB presented after CNV rises, next bit after each SCK rise.
    always @(posedge clk) cyc_n++;
    always @(posedge sck) sck_cnt++;
    always @(posedge cnv) begin
        n_cnv++;
        cur      = auto_inc ? 16'(32'h1000 + n_cnv - ovf_base) : sdo_word;
        sck_base = sck_cnt;
        rise_q.push_back(cyc_n);
    end
    assign sdo = ((sck_cnt - sck_base) < 16) ? cur[4'(15 - (sck_cnt - sck_base))] : 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb.WBS_CYC = 1; wb.WBS_STB = 1; wb.WBS_WE = 1; wb.WBS_RD = 0;
        wb.WBS_BYTE_STB = 4'hF; wb.WBS_ADR = {3'b000, r, 2'b00}; wb.WBS_WR_DAT = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.WBS_ACK) got = 1'b1;
        end
        @(negedge clk);
        wb.WBS_CYC = 0; wb.WBS_STB = 0; wb.WBS_WE = 0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL wb_write_ack reg=%0d: no ACK within 8 cycles", r);
        end
    endtask

    task automatic wb_read(input logic [2:0] r, output logic [31:0] d);
        bit got;
        got = 1'b0;
        d   = 32'hDEAD_BEEF;
        @(negedge clk);
        wb.WBS_CYC = 1; wb.WBS_STB = 1; wb.WBS_WE = 0; wb.WBS_RD = 1;
        wb.WBS_BYTE_STB = 4'hF; wb.WBS_ADR = {3'b000, r, 2'b00}; wb.WBS_WR_DAT = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.WBS_ACK) begin
                got = 1'b1;
                d   = wb.WBS_RD_DAT;
            end
        end
        @(negedge clk);
        wb.WBS_CYC = 0; wb.WBS_STB = 0; wb.WBS_RD = 0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL wb_read_ack reg=%0d: no ACK within 8 cycles", r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cnv, sck, sdma, irq, wb.WBS_ACK, wb.WBS_RD_DAT} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {cnv, sck, sdma, irq, wb.WBS_ACK, wb.WBS_RD_DAT});
        end
        @(negedge clk); rst_n = 1;
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_status: got %h required 00000100", d); end
        wb_read(3'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", d); end
    endtask

    task automatic test_conversion();
        logic [31:0] d;
        int cnv_hi, rises, first_rise, bad_gap, last_rise;
        logic prev_sck;
        cnv_hi = 0; rises = 0; first_rise = -1; bad_gap = 0; last_rise = -1; prev_sck = 0;
        sdo_word = 16'hA5C3;
        wb_write(3'd2, 32'd3);
        wb_write(3'd3, 32'd0);
        wb_write(3'd0, 32'h2);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (cnv) cnv_hi++;
            if (sck && !prev_sck) begin
                rises++;
                if (first_rise < 0) first_rise = i;
                if (last_rise >= 0 && i - last_rise != 2) bad_gap++;
                last_rise = i;
            end
            prev_sck = sck;
        end
        n_checks++;
        if (cnv_hi !== 4) begin n_fail++; $display("FAIL conv_cnv_width: got %0d required 4", cnv_hi); end
        n_checks++;
        if (rises !== 16) begin n_fail++; $display("FAIL conv_sck_pulses: got %0d required 16", rises); end
        n_checks++;
        if (bad_gap !== 0) begin n_fail++; $display("FAIL conv_sck_period: %0d gaps not 2", bad_gap); end
        n_checks++;
        if (first_rise !== 5) begin n_fail++; $display("FAIL conv_first_sck: got %0d required 5", first_rise); end
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL conv_status: got %h required 00000001", d); end
        wb_read(3'd5, d);
        n_checks++;
        if (d !== 32'h8000_A5C3) begin n_fail++; $display("FAIL conv_data1: got %h required 8000a5c3", d); end
        wb_read(3'd5, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL conv_data2: got %h required 0", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] last;
        do_reset();
        ovf_base = n_cnv;
        auto_inc = 1'b1;
        wb_write(3'd1, 32'd64);
        wb_write(3'd2, 32'd3);
        wb_write(3'd0, 32'h1);
        for (int i = 0; i < 1300 && (n_cnv - ovf_base) < 17; i++) @(posedge clk);
        n_checks++;
        if (n_cnv - ovf_base !== 17) begin n_fail++; $display("FAIL ovf_conv_count: got %0d required 17", n_cnv - ovf_base); end
        repeat (50) @(posedge clk);
        wb_write(3'd0, 32'h0);
        auto_inc = 1'b0;
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0001_0210) begin n_fail++; $display("FAIL ovf_status: got %h required 00010210", d); end
        wb_read(3'd5, d);
        n_checks++;
        if (d !== 32'h8000_1001) begin n_fail++; $display("FAIL ovf_first: got %h required 80001001", d); end
        last = d;
        for (int i = 0; i < 15; i++) wb_read(3'd5, last);
        n_checks++;
        if (last !== 32'h8000_1010) begin n_fail++; $display("FAIL ovf_sixteenth: got %h required 80001010", last); end
        wb_read(3'd5, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_no_17th: got %h required 0", d); end
        wb_write(3'd4, 32'h0001_0000);
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL ovf_w1c: got %h required 00000100", d); end
    endtask

    task automatic test_miss();
        logic [31:0] d;
        int unsigned r0;
        do_reset();
        r0 = rise_q.size();
        wb_write(3'd1, 32'd20);
        wb_write(3'd2, 32'd3);
        wb_write(3'd0, 32'h1);
        repeat (10) @(posedge clk);
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL miss_early: got %h required 00000100", d); end
        for (int i = 0; i < 200 && rise_q.size() < r0 + 2; i++) @(posedge clk);
        wb_read(3'd4, d);
        n_checks++;
        if (d[17] !== 1'b1) begin n_fail++; $display("FAIL miss_flag: got %b required 1", d[17]); end
        n_checks++;
        if (rise_q.size() < r0 + 2) begin
            n_fail++; $display("FAIL miss_spacing: got %0d CNV rises required 2", rise_q.size() - r0);
        end else if (rise_q[r0 + 1] - rise_q[r0] !== 40) begin
            n_fail++; $display("FAIL miss_spacing: got %0d required 40", rise_q[r0 + 1] - rise_q[r0]);
        end
        wb_write(3'd0, 32'h0);
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        int first_sdma, first_irq;
        first_sdma = -1; first_irq = -1;
        do_reset();
        wb_write(3'd6, 32'd4);
        for (int k = 0; k < 3; k++) begin
            wb_write(3'd0, 32'hA);
            repeat (40) @(posedge clk);
        end
        #1;
        n_checks++;
        if ({sdma, irq} !== 2'b00) begin n_fail++; $display("FAIL thr_below: got %b required 00", {sdma, irq}); end
        wb_write(3'd0, 32'hA);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sdma && first_sdma < 0) first_sdma = i;
            if (irq && first_irq < 0)   first_irq = i;
        end
        n_checks++;
        if (first_sdma !== 35) begin n_fail++; $display("FAIL thr_sdma_rise: got %0d required 35", first_sdma); end
        n_checks++;
        if (first_irq !== 35) begin n_fail++; $display("FAIL thr_irq_rise: got %0d required 35", first_irq); end
        wb_read(3'd5, d);
        n_checks++;
        if ({sdma, irq} !== 2'b11) begin n_fail++; $display("FAIL thr_pop_cycle: got %b required 11", {sdma, irq}); end
        @(posedge clk); #1;
        n_checks++;
        if ({sdma, irq} !== 2'b00) begin n_fail++; $display("FAIL thr_fall: got %b required 00", {sdma, irq}); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int rises, late_rises, late_cnv;
        logic prev_sck;
        rises = 0; late_rises = 0; late_cnv = 0; prev_sck = 0;
        do_reset();
        sdo_word = 16'h3C5A;
        wb_write(3'd2, 32'd3);
        wb_write(3'd0, 32'h2);
        repeat (45) @(posedge clk);
        wb_write(3'd1, 32'd1000);
        wb_write(3'd0, 32'h1);
        for (int i = 0; i < 100 && rises < 8; i++) begin
            @(posedge clk); #1;
            if (sck && !prev_sck) rises++;
            prev_sck = sck;
        end
        wb_write(3'd0, 32'h0);
        n_checks++;
        if (sck !== 1'b0) begin n_fail++; $display("FAIL abort_sck: got %b required 0", sck); end
        prev_sck = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (sck && !prev_sck) late_rises++;
            if (cnv) late_cnv++;
            prev_sck = sck;
        end
        n_checks++;
        if (late_rises + late_cnv !== 0) begin
            n_fail++; $display("FAIL abort_idle: got %0d SCK rises %0d CNV cycles required 0", late_rises, late_cnv);
        end
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL abort_level: got %h required 00000001", d); end
    endtask

    task automatic test_reset_mid_conv();
        logic [31:0] d;
        do_reset();
        wb_write(3'd6, 32'd1);
        wb_write(3'd1, 32'h55);
        wb_write(3'd2, 32'd20);
        wb_write(3'd0, 32'hA);
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if ({sdma, irq} !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre: got %b required 11", {sdma, irq}); end
        wb_write(3'd0, 32'hA);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (cnv !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_conv: got %b required 1", cnv); end
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({cnv, sck, sdma, irq} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_outputs: got %b required 0000", {cnv, sck, sdma, irq}); end
        @(negedge clk); rst_n = 1;
        wb_read(3'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h required 0", d); end
        wb_read(3'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_period: got %h required 0", d); end
        wb_read(3'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_tconv: got %h required 0", d); end
        wb_read(3'd6, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_thresh: got %h required 0", d); end
        wb_read(3'd4, d);
        n_checks++;
        if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL rstmid_status: got %h required 00000100", d); end
    endtask

    initial begin
        wb.WBS_CYC = 0; wb.WBS_STB = 0; wb.WBS_WE = 0; wb.WBS_RD = 0;
        wb.WBS_BYTE_STB = 4'h0; wb.WBS_ADR = '0; wb.WBS_WR_DAT = '0;
        test_reset();
        test_conversion();
        test_overflow();
        test_miss();
        test_threshold();
        test_abort();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
